// File: rtl/key_cd_schedule_reg.sv
// key_cd_schedule_reg
// C/D key-half register for an extended DES-style key schedule. Loads the
// PC-1 halves, then walks them through ROUNDS circular rotations using a
// per-round 1/2-bit schedule, presenting each round on a valid/ready stream
// towards the PC-2 subkey stage. Decrypt order starts from the fully rotated
// halves and rotates right, so round k of a decrypt equals round
// ROUNDS-1-k of the encrypt sequence for symmetric schedules.
module key_cd_schedule_reg #(
  parameter int                HALF_W     = 56,
  parameter int                ROUNDS     = 16,
  parameter logic [ROUNDS-1:0] SHIFT_MASK = 16'h8103,
  localparam int               IDX_W      = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load_valid,
  output logic              Load_ready,
  input  logic [HALF_W-1:0] C_in,
  input  logic [HALF_W-1:0] D_in,
  input  logic              Decrypt,
  output logic              Round_valid,
  input  logic              Round_ready,
  output logic [IDX_W-1:0]  Round_idx,
  output logic [HALF_W-1:0] C_out,
  output logic [HALF_W-1:0] D_out,
  output logic              Busy,
  output logic              Done
);

  // Total rotation over all rounds, reduced into the half width. The
  // decrypt order starts from this fully rotated position.
  function automatic int calc_total();
    int sum;
    sum = 0;
    for (int r = 0; r < ROUNDS; r++) begin
      sum += SHIFT_MASK[r] ? 1 : 2;
    end
    return sum % HALF_W;
  endfunction

  localparam int               TOTAL    = calc_total();
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  // Circular left rotation by amt (amt < HALF_W).
  function automatic logic [HALF_W-1:0] rol(input logic [HALF_W-1:0] x, input int amt);
    logic [2*HALF_W-1:0] t;
    t = {x, x} << amt;
    return t[2*HALF_W-1:HALF_W];
  endfunction

  // Circular right rotation by amt (amt < HALF_W).
  function automatic logic [HALF_W-1:0] ror(input logic [HALF_W-1:0] x, input int amt);
    logic [2*HALF_W-1:0] t;
    t = {x, x} >> amt;
    return t[HALF_W-1:0];
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [HALF_W-1:0]   c_reg, c_next;
  logic [HALF_W-1:0]   d_reg, d_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic                decrypt_reg, decrypt_next;

  // Per-round rotation amount, decoded once from the mask.
  logic [1:0]          shift_tab [ROUNDS];

  for (genvar gi = 0; gi < ROUNDS; gi++) begin : g_shift_tab
    assign shift_tab[gi] = SHIFT_MASK[gi] ? 2'd1 : 2'd2;
  end

  // Encrypt uses the amount of the round being entered; decrypt undoes the
  // amount of the mirrored encrypt round.
  logic [IDX_W-1:0]    enc_sel;
  logic [IDX_W-1:0]    dec_sel;
  logic [1:0]          enc_amt;
  logic [1:0]          dec_amt;

  assign enc_sel = idx_reg + 1'b1;
  assign dec_sel = LAST_IDX - idx_reg;
  assign enc_amt = shift_tab[enc_sel];
  assign dec_amt = shift_tab[dec_sel];

  // Handshake and status outputs decode straight from the state register.
  assign Load_ready  = (state_reg == ST_IDLE);
  assign Round_valid = (state_reg == ST_RUN);
  assign Busy        = (state_reg == ST_RUN);
  assign Done        = (state_reg == ST_DONE);
  assign Round_idx   = idx_reg;
  assign C_out       = c_reg;
  assign D_out       = d_reg;

  // State and datapath registers; reset clears everything and aborts a run.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg   <= ST_IDLE;
      c_reg       <= '0;
      d_reg       <= '0;
      idx_reg     <= '0;
      decrypt_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      c_reg       <= c_next;
      d_reg       <= d_next;
      idx_reg     <= idx_next;
      decrypt_reg <= decrypt_next;
    end
  end

  // Next-state and datapath update: load, advance on transfer, hold on stall.
  always_comb begin
    state_next   = state_reg;
    c_next       = c_reg;
    d_next       = d_reg;
    idx_next     = idx_reg;
    decrypt_next = decrypt_reg;

    case (state_reg)
      ST_IDLE: begin
        if (Load_valid) begin
          state_next   = ST_RUN;
          idx_next     = '0;
          decrypt_next = Decrypt;
          if (Decrypt) begin
            c_next = rol(C_in, TOTAL);
            d_next = rol(D_in, TOTAL);
          end else begin
            c_next = rol(C_in, int'(shift_tab[0]));
            d_next = rol(D_in, int'(shift_tab[0]));
          end
        end
      end

      ST_RUN: begin
        if (Round_ready) begin
          if (idx_reg == LAST_IDX) begin
            // Halves keep the last round's value after the stream ends.
            state_next = ST_DONE;
          end else begin
            idx_next = enc_sel;
            if (decrypt_reg) begin
              c_next = ror(c_reg, int'(dec_amt));
              d_next = ror(d_reg, int'(dec_amt));
            end else begin
              c_next = rol(c_reg, int'(enc_amt));
              d_next = rol(d_reg, int'(enc_amt));
            end
          end
        end
      end

      ST_DONE: begin
        // One-cycle Done pulse; loads are refused until back in idle.
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
